// File: rtl/router_pkt_tx_pkg.sv
// router_tx_pkg: shared widths, FSM state type and header packing for router_pkt_tx
package router_tx_pkg;
  localparam int ADDR_W = 2;
  localparam int LEN_W = 6;
  localparam int DATA_W = 8;
  localparam logic [ADDR_W-1:0] INVALID_ADDR = 2'b11;
  typedef enum logic [2:0] {IDLE, LOAD, HEADER, PAYLOAD, PARITY, GAP} state_t;
  function automatic logic [DATA_W-1:0] make_header(input logic [LEN_W-1:0] len, input logic [ADDR_W-1:0] addr);
    return {len, addr};
  endfunction
endpackage

// File: rtl/router_pkt_tx_if.sv
// router_pkt_tx_if: upstream payload stream, command handshake and router-side pins
interface router_pkt_tx_if;
  import router_tx_pkg::*;
  logic start;
  logic start_ready;
  logic [ADDR_W-1:0] dest_addr;
  logic [LEN_W-1:0] pld_len;
  logic [DATA_W-1:0] pl_data;
  logic pl_valid;
  logic pl_ready;
  logic busy;
  logic err;
  logic packet_valid;
  logic [DATA_W-1:0] tx_data;
  logic cmd_err;
  logic tx_done;
  logic [7:0] err_count;
  modport slave(
    input start, dest_addr, pld_len, pl_data, pl_valid, busy, err,
    output start_ready, pl_ready, packet_valid, tx_data, cmd_err, tx_done, err_count
  );
  modport master(
    output start, dest_addr, pld_len, pl_data, pl_valid, busy, err,
    input start_ready, pl_ready, packet_valid, tx_data, cmd_err, tx_done, err_count
  );
endinterface

// File: rtl/router_pkt_tx_buf.sv
// router_tx_buf: 64x8 payload store, one write port, asynchronous read port
module router_tx_buf
  import router_tx_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [LEN_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [LEN_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [1<<LEN_W];
  // payload write; contents need no reset
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/router_pkt_tx.sv
// router_pkt_tx: buffers one payload and sends header/payload/parity to the router; ROUTER_TX_PARITY_INJ_EN adds corrupt_parity
module router_pkt_tx
  import router_tx_pkg::*;
#(
  parameter int GAP_CYCLES = 3
) (
  input logic clk,
  input logic resetn,
`ifdef ROUTER_TX_PARITY_INJ_EN
  input logic corrupt_parity,
`endif
  router_pkt_tx_if.slave bus
);
  state_t state, state_d;
  logic [ADDR_W-1:0] addr, addr_d;
  logic [LEN_W-1:0] len, len_d, cnt, cnt_d;
  logic [DATA_W-1:0] par, par_d, tx, tx_d, rdata;
  logic [3:0] gcnt, gcnt_d;
  logic pv, pv_d, inj, inj_d, we, bad, last;
  logic cmd_err, cmd_err_d, tx_done, tx_done_d, err_prev;
  logic [7:0] err_count;
  router_tx_buf u_buf (
    .clk(clk), .we(we), .waddr(cnt), .wdata(bus.pl_data), .raddr(cnt_d), .rdata(rdata)
  );
  // next state; tx outputs are registered from the next state so they hold during busy stalls
  always_comb begin
    state_d = state;
    addr_d = addr;
    len_d = len;
    cnt_d = cnt;
    par_d = par;
    gcnt_d = gcnt;
    inj_d = inj;
    we = 1'b0;
    bad = bus.dest_addr == INVALID_ADDR || bus.pld_len == '0;
    last = cnt == len - 6'd1;
    case (state)
      IDLE: if (bus.start && !bad) begin
        state_d = LOAD;
        addr_d = bus.dest_addr;
        len_d = bus.pld_len;
        par_d = make_header(bus.pld_len, bus.dest_addr);
        cnt_d = '0;
`ifdef ROUTER_TX_PARITY_INJ_EN
        inj_d = corrupt_parity;
`endif
      end
      LOAD: if (bus.pl_valid) begin
        we = 1'b1;
        par_d = par ^ bus.pl_data;
        cnt_d = last ? '0 : cnt + 6'd1;
        state_d = last ? HEADER : LOAD;
      end
      HEADER: if (!bus.busy) state_d = PAYLOAD;
      PAYLOAD: if (!bus.busy) begin
        state_d = last ? PARITY : PAYLOAD;
        cnt_d = last ? cnt : cnt + 6'd1;
      end
      PARITY: if (!bus.busy) begin
        state_d = GAP;
        gcnt_d = '0;
      end
      GAP: begin
        state_d = gcnt == 4'(GAP_CYCLES - 1) ? IDLE : GAP;
        gcnt_d = gcnt + 4'd1;
      end
      default: state_d = IDLE;
    endcase
    pv_d = state_d == HEADER || state_d == PAYLOAD;
    tx_d = state_d == HEADER ? make_header(len_d, addr_d) :
           state_d == PAYLOAD ? rdata :
           state_d == PARITY ? par_d ^ {DATA_W{inj_d}} : '0;
    cmd_err_d = state == IDLE && bus.start && bad;
    tx_done_d = state == PARITY && !bus.busy;
  end
  // state and output registers; reset aborts any packet in flight
  always_ff @(posedge clk) begin
    if (resetn) begin
      state <= IDLE;
      addr <= '0;
      len <= '0;
      cnt <= '0;
      par <= '0;
      gcnt <= '0;
      inj <= 1'b0;
      pv <= 1'b0;
      tx <= '0;
      cmd_err <= 1'b0;
      tx_done <= 1'b0;
    end else begin
      state <= state_d;
      addr <= addr_d;
      len <= len_d;
      cnt <= cnt_d;
      par <= par_d;
      gcnt <= gcnt_d;
      inj <= inj_d;
      pv <= pv_d;
      tx <= tx_d;
      cmd_err <= cmd_err_d;
      tx_done <= tx_done_d;
    end
  end
  // router err rising edges during GAP, saturating
  always_ff @(posedge clk) begin
    err_prev <= resetn ? 1'b0 : bus.err;
    if (resetn) err_count <= '0;
    else if (state == GAP && bus.err && !err_prev && err_count != 8'hFF) err_count <= err_count + 8'd1;
  end
  assign bus.start_ready = state == IDLE;
  assign bus.pl_ready = state == LOAD;
  assign bus.packet_valid = pv;
  assign bus.tx_data = tx;
  assign bus.cmd_err = cmd_err;
  assign bus.tx_done = tx_done;
  assign bus.err_count = err_count;
endmodule

// File: tb/tb_router_pkt_tx.sv
// tb_router_pkt_tx: directed self-checking bench for router_pkt_tx
module tb_router_pkt_tx;
  import router_tx_pkg::*;
  logic clk = 1'b0;
  logic resetn;
`ifdef ROUTER_TX_PARITY_INJ_EN
  logic corrupt_parity = 1'b0;
`endif
  int checks = 0;
  int failures = 0;
  logic [7:0] pay [64];
  logic [7:0] par;
  router_pkt_tx_if bus();
  router_pkt_tx #(.GAP_CYCLES(3)) dut (
    .clk(clk),
    .resetn(resetn),
`ifdef ROUTER_TX_PARITY_INJ_EN
    .corrupt_parity(corrupt_parity),
`endif
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(negedge clk);
  endtask
  task automatic wire_chk(input string tag, input logic pv, input logic [7:0] d);
    chk({tag, "_pv"}, bus.packet_valid, pv);
    chk({tag, "_data"}, bus.tx_data, d);
  endtask
  task automatic start_pkt(input logic [1:0] a, input logic [5:0] l);
    bus.start = 1'b1;
    bus.dest_addr = a;
    bus.pld_len = l;
    step();
    bus.start = 1'b0;
  endtask
  task automatic feed(input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      while (gaps && $urandom_range(0, 2) == 0) begin
        bus.pl_valid = 1'b0;
        step();
      end
      chk("pl_ready_load", bus.pl_ready, 1);
      bus.pl_valid = 1'b1;
      bus.pl_data = pay[i];
      step();
    end
    bus.pl_valid = 1'b0;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "timeout");
  end
  initial begin
    bus.start = 0; bus.dest_addr = 0; bus.pld_len = 0; bus.pl_data = 0;
    bus.pl_valid = 0; bus.busy = 0; bus.err = 0; resetn = 1;
    repeat (2) step();
    resetn = 0;
    wire_chk("rst", 0, 8'h00);
    chk("rst_pl_ready", bus.pl_ready, 0);
    chk("rst_cmd_err", bus.cmd_err, 0);
    chk("rst_tx_done", bus.tx_done, 0);
    chk("rst_err_count", bus.err_count, 0);
    chk("rst_start_ready", bus.start_ready, 1);
    // basic packet addr=1 len=3
    pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33;
    start_pkt(1, 3);
    chk("t1_start_ready_load", bus.start_ready, 0);
    feed(3, 0);
    wire_chk("t1_hdr", 1, 8'h0D);
    chk("t1_pl_ready_hdr", bus.pl_ready, 0);
    step(); wire_chk("t1_b0", 1, 8'h11);
    step(); wire_chk("t1_b1", 1, 8'h22);
    step(); wire_chk("t1_b2", 1, 8'h33);
    step(); wire_chk("t1_par", 0, 8'h0D);
    chk("t1_tx_done_early", bus.tx_done, 0);
    step(); chk("t1_tx_done", bus.tx_done, 1);
    wire_chk("t1_gap", 0, 8'h00);
    bus.err = 1;
    step(); chk("t1_err_count", bus.err_count, 1);
    chk("t1_tx_done_pulse", bus.tx_done, 0);
    chk("t1_gap_ready1", bus.start_ready, 0);
    bus.err = 0;
    step(); chk("t1_gap_ready2", bus.start_ready, 0);
    step(); chk("t1_idle_ready", bus.start_ready, 1);
    // rejected commands; err edge outside GAP is not counted
    bus.err = 1;
    start_pkt(3, 5);
    chk("t3a_cmd_err", bus.cmd_err, 1);
    chk("t3a_start_ready", bus.start_ready, 1);
    chk("t3a_pv", bus.packet_valid, 0);
    chk("t3a_pl_ready", bus.pl_ready, 0);
    bus.err = 0;
    step(); chk("t3a_cmd_err_pulse", bus.cmd_err, 0);
    start_pkt(1, 0);
    chk("t3b_cmd_err", bus.cmd_err, 1);
    chk("t3b_start_ready", bus.start_ready, 1);
    step(); chk("t3b_cmd_err_pulse", bus.cmd_err, 0);
    chk("t3b_pv", bus.packet_valid, 0);
    chk("t3_err_count", bus.err_count, 1);
    // busy stall on first payload byte; busy during LOAD ignored
    pay[0] = 8'hA5; pay[1] = 8'h3C;
    start_pkt(0, 2);
    bus.busy = 1;
    feed(2, 0);
    bus.busy = 0;
    wire_chk("t2_hdr", 1, 8'h08);
    step(); wire_chk("t2_b0", 1, 8'hA5);
    bus.busy = 1;
    step(); wire_chk("t2_b0_hold1", 1, 8'hA5);
    step(); wire_chk("t2_b0_hold2", 1, 8'hA5);
    bus.busy = 0;
    step(); wire_chk("t2_b1", 1, 8'h3C);
    step(); wire_chk("t2_par", 0, 8'h91);
    step(); chk("t2_tx_done", bus.tx_done, 1);
    repeat (3) step();
    chk("t2_idle_ready", bus.start_ready, 1);
    // max-length packet with random payload and valid gaps
    par = 8'hFE;
    for (int i = 0; i < 63; i++) begin
      pay[i] = 8'($urandom);
      par = par ^ pay[i];
    end
    start_pkt(2, 63);
    feed(63, 1);
    wire_chk("t4_hdr", 1, 8'hFE);
    for (int i = 0; i < 63; i++) begin
      step(); wire_chk("t4_pay", 1, pay[i]);
    end
    step(); wire_chk("t4_par", 0, par);
    step(); chk("t4_tx_done", bus.tx_done, 1);
    step(); step();
    pay[0] = 8'hDE; pay[1] = 8'hAD; pay[2] = 8'hBE; pay[3] = 8'hEF;
    bus.start = 1; bus.dest_addr = 1; bus.pld_len = 4;
    step(); chk("t4_gap_ignored", bus.pl_ready, 0);
    chk("t4_ready_after_gap", bus.start_ready, 1);
    step(); bus.start = 0;
    chk("t4_accept_after_gap", bus.pl_ready, 1);
    chk("t4_busy_after_accept", bus.start_ready, 0);
    // reset in the middle of the payload
    feed(4, 0);
    wire_chk("t5_hdr", 1, 8'h11);
    step(); wire_chk("t5_b0", 1, 8'hDE);
    step(); wire_chk("t5_b1", 1, 8'hAD);
    resetn = 1;
    step(); wire_chk("t5_abort", 0, 8'h00);
    chk("t5_start_ready", bus.start_ready, 1);
    chk("t5_pl_ready", bus.pl_ready, 0);
    chk("t5_err_count", bus.err_count, 0);
    chk("t5_tx_done", bus.tx_done, 0);
    resetn = 0;
    step(); wire_chk("t5_idle", 0, 8'h00);
    chk("t5_idle_ready", bus.start_ready, 1);
`ifdef ROUTER_TX_PARITY_INJ_EN
    pay[0] = 8'h00;
    corrupt_parity = 1;
    start_pkt(1, 1);
    corrupt_parity = 0;
    feed(1, 0);
    wire_chk("t6_hdr", 1, 8'h05);
    step(); wire_chk("t6_b0", 1, 8'h00);
    step(); wire_chk("t6_par", 0, 8'hFA);
    step(); chk("t6_tx_done", bus.tx_done, 1);
    bus.err = 1;
    step(); chk("t6_err_count", bus.err_count, 1);
    bus.err = 0;
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/router_pkt_tx.md
Name: router_pkt_tx

Overview:
Packet transmitter that drives the input side of the 1x3 router.
- Buffers one packet payload from an upstream byte stream.
- Emits it as header, payload bytes, then parity byte, honouring the router's busy stall.
- Monitors the router's err flag after each packet.
- Sits between the test or system source and the router's packet_valid/datain/busy/err pins.

Parameters:
GAP_CYCLES, 3, idle cycles after the parity byte before the next packet may start; range 2..15.
MAX_LEN, 63, maximum payload length; fixed by the 6-bit header length field.

Ports:
clk  in  1  single clock; all logic on rising edge
resetn  in  1  synchronous, active-high reset (1 = reset)
start  in  1  request to send a packet; accepted when start && start_ready
start_ready  out  1  high only in IDLE
dest_addr  in  2  destination port 0..2, sampled at accept
pld_len  in  6  payload length 1..63, sampled at accept
pl_data  in  8  payload byte from upstream
pl_valid  in  1  pl_data valid
pl_ready  out  1  block accepts pl_data
busy  in  1  router busy; stalls transfer
err  in  1  router parity error flag
packet_valid  out  1  registered; to router
tx_data  out  8  registered; to router datain
cmd_err  out  1  one-cycle pulse: start rejected
tx_done  out  1  one-cycle pulse: parity byte transferred
err_count  out  8  saturating count of router err rising edges seen in GAP

Behaviour:
Reset (resetn=1 at an edge):
- State goes to IDLE.
- Outputs: packet_valid=0, tx_data=0, pl_ready=0, cmd_err=0, tx_done=0, err_count=0, start_ready=1 (next cycle).
- Buffer contents are don't-care.
- Reset mid-packet aborts immediately. No parity byte is sent; packet_valid drops at that edge.

State machine: IDLE -> LOAD -> HEADER -> PAYLOAD -> PARITY -> GAP -> IDLE.

IDLE:
- On start with dest_addr==3 or pld_len==0: reject. cmd_err pulses the next cycle; stay in IDLE.
- Otherwise: latch addr/len, set parity accumulator = {pld_len,dest_addr}, count=0, go to LOAD.

LOAD:
- pl_ready=1.
- Each pl_valid&&pl_ready cycle: write pl_data to buf[count], XOR it into parity, count++.
- After the byte where count reaches len-1, go to HEADER with pl_ready low from the next cycle.
- Gaps in pl_valid are permitted.

Transfer rule:
- In HEADER/PAYLOAD/PARITY, the byte on tx_data is transferred on any cycle with busy=0.
- While busy=1, packet_valid and tx_data hold unchanged.

HEADER:
- packet_valid=1, tx_data={len,addr}.
- On transfer: present buf[0], idx=0, go to PAYLOAD.

PAYLOAD:
- packet_valid=1, tx_data=buf[idx].
- On transfer: if idx==len-1, go to PARITY; else idx++ and present buf[idx+1] next cycle.

PARITY:
- packet_valid=0, tx_data=parity (XOR of header and all payload bytes).
- On transfer: tx_done pulses, go to GAP.

GAP:
- packet_valid=0, tx_data=0 for GAP_CYCLES cycles, then IDLE.
- An err 0->1 edge within GAP increments err_count, saturating at 255.

Latency: with busy=0 throughout, the header appears 1 cycle after the last LOAD byte. Packet length on the wire is len+2 cycles.

Simultaneous events: start is ignored outside IDLE. busy during LOAD has no effect.

Optional Feature:
Macro ROUTER_TX_PARITY_INJ_EN.
- Defined: adds input port corrupt_parity (1 bit), sampled at start accept. When set, the PARITY byte is inverted (~parity).
- Undefined: port absent; parity is always correct.

Decomposition:
Package router_tx_pkg:
- state enum (IDLE, LOAD, HEADER, PAYLOAD, PARITY, GAP)
- ADDR_W=2, LEN_W=6, DATA_W=8
- INVALID_ADDR=2'b11
- function make_header(len,addr)

Sub-module router_tx_buf:
- 64x8 register file
- one write port (we, waddr, wdata); one asynchronous read port (raddr, rdata)

Test Plan:
1. start, addr=1, len=3, payload 0x11,0x22,0x33, busy=0 -> wire shows 0x0D(pv=1), 0x11, 0x22, 0x33 (pv=1), then 0x0D^0x11^0x22^0x33=0x0D (pv=0); tx_done one cycle.
2. addr=0, len=2, busy=1 for 2 cycles right after header -> first payload byte held 2 extra cycles; no byte skipped or duplicated; parity correct.
3. start with addr=3 or len=0 -> cmd_err pulse, start_ready stays 1, packet_valid never asserts.
4. addr=2, len=63 with random pl_valid gaps -> 65 bytes transferred; parity matches the model; next start accepted only after GAP_CYCLES.
5. resetn=1 in PAYLOAD mid-packet -> packet_valid=0 and tx_data=0 next cycle; IDLE; err_count=0.
6. With ROUTER_TX_PARITY_INJ_EN defined, corrupt_parity=1 -> inverted parity byte sent; router err rises in GAP; err_count increments to 1.
